// File: rtl/ft2232h_frame_tx.sv
// FT2232H sync-FIFO frame transmitter: snapshots a capture word and streams it as
// header / sequence number / zero-padded payload bytes, resuming cleanly across TXE# stalls.
module ft2232h_frame_tx #(
  parameter int unsigned DATA_WIDTH  = 14,
  parameter int unsigned SAMPLES     = 40,
  parameter int unsigned HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BYTE = 8'hFF,
  parameter int unsigned SEQ_EN      = 1,
  parameter int unsigned MAX_STALL   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          txe,
  input  logic [DATA_WIDTH*SAMPLES-1:0] data,
  input  logic                          enable,
  output logic                          wr,
  output logic [7:0]                    data_out,
  output logic                          busy,
  output logic                          done,
  output logic                          dropped,
  output logic                          abort
);

  localparam int unsigned NBITS       = DATA_WIDTH * SAMPLES;
  localparam int unsigned PAY_BYTES   = (NBITS + 7) / 8;
  localparam int unsigned PAY_BITS    = PAY_BYTES * 8;
  localparam int unsigned HDR         = (HEADER_EN != 0) ? 1 : 0;
  localparam int unsigned SEQB        = (SEQ_EN != 0) ? 2 : 0;
  localparam int unsigned FRAME_BYTES = HDR + SEQB + PAY_BYTES;
  localparam int unsigned IDX_W       = (FRAME_BYTES < 2) ? 1 : $clog2(FRAME_BYTES);
  localparam int unsigned STALL_W     = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam int unsigned STALL_LIM   = (MAX_STALL == 0) ? 0 : MAX_STALL - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_n;
  logic                 pending, pending_n;
  logic                 en_q;
  logic [15:0]          seq, seq_n;
  logic [IDX_W-1:0]     byte_idx, idx_n;
  logic [STALL_W-1:0]   stall_cnt, stall_n;
  logic [PAY_BITS-1:0]  shadow, shadow_n;
  logic                 wr_n, busy_n, done_n, dropped_n, abort_n;
  logic [7:0]           dout_n;

  function automatic logic [7:0] frame_byte(input int unsigned idx,
                                            input logic [PAY_BITS-1:0] pay,
                                            input logic [15:0] s);
    logic [PAY_BITS-1:0] sh;
    frame_byte = '0;
    sh         = '0;
    if (HDR == 1 && idx == 0)                 frame_byte = HEADER_BYTE;
    else if (SEQB == 2 && idx == HDR)         frame_byte = s[15:8];
    else if (SEQB == 2 && idx == HDR + 1)     frame_byte = s[7:0];
    else if (idx >= HDR + SEQB) begin
      sh         = pay >> (8 * (idx - HDR - SEQB));
      frame_byte = sh[7:0];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      en_q      <= 1'b0;
      seq       <= '0;
      byte_idx  <= '0;
      stall_cnt <= '0;
      shadow    <= '0;
      wr        <= 1'b1;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dropped   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      en_q      <= enable;
      seq       <= seq_n;
      byte_idx  <= idx_n;
      stall_cnt <= stall_n;
      shadow    <= shadow_n;
      wr        <= wr_n;
      data_out  <= dout_n;
      busy      <= busy_n;
      done      <= done_n;
      dropped   <= dropped_n;
      abort     <= abort_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    seq_n     = seq;
    idx_n     = byte_idx;
    stall_n   = stall_cnt;
    shadow_n  = shadow;
    wr_n      = wr;
    dout_n    = data_out;
    busy_n    = busy;
    done_n    = 1'b0;
    dropped_n = 1'b0;
    abort_n   = 1'b0;
    unique case (state)
      IDLE: begin
        // A start consumes the pending slot first; an enable seen alongside it re-queues.
        if (enable || pending) begin
          shadow_n  = PAY_BITS'(data);
          pending_n = pending & enable;
          idx_n     = '0;
          stall_n   = '0;
          dout_n    = frame_byte(0, PAY_BITS'(data), seq);
          wr_n      = 1'b0;
          busy_n    = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: begin
        if (!wr && !txe) begin
          stall_n = '0;
          if (byte_idx == IDX_W'(FRAME_BYTES - 1)) begin
            wr_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            seq_n   = seq + 16'd1;
            state_n = IDLE;
          end else begin
            idx_n  = byte_idx + 1'b1;
            dout_n = frame_byte(32'(byte_idx) + 32'd1, shadow, seq);
          end
        end else if (txe) begin
          if (MAX_STALL != 0 && stall_cnt == STALL_W'(STALL_LIM)) begin
            wr_n    = 1'b1;
            busy_n  = 1'b0;
            abort_n = 1'b1;
            state_n = IDLE;
          end else begin
            stall_n = stall_cnt + 1'b1;
          end
        end
        // A held enable level is one request; only a fresh rising edge can be dropped.
        if (enable) begin
          if (!pending)   pending_n = 1'b1;
          else if (!en_q) dropped_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
